// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exception flag layout, rounding-mode encodings
// and the rounding-mode legality check used by the FPU issue controllers.
package fpu_pkg;

    // Exception flags, MSB to LSB: {NV, DZ, OF, UF, NX}
    typedef logic [4:0] fflags_t;

    localparam int unsigned FF_NV = 4;
    localparam int unsigned FF_DZ = 3;
    localparam int unsigned FF_OF = 2;
    localparam int unsigned FF_UF = 1;
    localparam int unsigned FF_NX = 0;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } rm_e;

    // True for a rounding mode the datapath can execute. DYN is not
    // legal here because it must already have been replaced by frm.
    function automatic logic rm_is_legal(input logic [2:0] rm);
        return (rm == RNE) || (rm == RTZ) || (rm == RDN) ||
               (rm == RUP) || (rm == RMM);
    endfunction

endpackage

// File: rtl/f_pipe_tracker.sv
// Occupancy/payload tracker for a hold-type FP datapath pipeline.
// Each stage carries a valid bit and an opaque payload. All stages shift
// together unless held; flush clears every valid bit on the next edge.
// Bubbles shift like ops, so ordering is strictly in-order.
module f_pipe_tracker #(
    parameter int STAGES = 3,
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              any_valid
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];

    // Next-state: flush wins over hold; otherwise shift one stage or hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
        end else if (!hold) begin
            valid_d[0] = in_valid;
            data_d[0]  = in_data;
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    // Stage registers; payload is reset too so the output tag is deterministic.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign any_valid = |valid_q;

endmodule

// File: rtl/f_mult_ctrl.sv
// Issue/sequencing controller for the FP multiplier datapath.
// Accepts ops over valid/ready, resolves the rounding mode at issue,
// tracks per-stage occupancy and destination tags, presents results
// with backpressure and accumulates sticky exception flags.
module f_mult_ctrl
    import fpu_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_rm,
    input  logic [TAG_W-1:0]  in_rd,
    input  logic [2:0]        frm,
    input  logic              flush,
    output logic [STAGES-1:0] stage_en,
    output logic [2:0]        mul_rm,
    input  logic [4:0]        mul_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_rd,
    output logic              out_illegal,
    input  logic              fflags_clr,
    output logic [4:0]        fflags_acc,
    output logic              busy
);

    localparam int ENTRY_W = TAG_W + 1;

    logic               stall;
    logic               accept;
    logic               out_hs;
    logic               issue_illegal;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] entry_out;
    fflags_t            fflags_q, fflags_d;

    // Handshake and rounding-mode resolution at issue.
    always_comb begin
        stall         = out_valid & ~out_ready;
        in_ready      = ~stall & ~flush;
        accept        = in_valid & in_ready;
        out_hs        = out_valid & out_ready;
        mul_rm        = (in_rm == DYN) ? frm : in_rm;
        issue_illegal = ~rm_is_legal(mul_rm);
        entry_in      = {issue_illegal, in_rd};
    end

    // Datapath registers move exactly when the tracker does.
    assign stage_en = {STAGES{~stall}};

    f_pipe_tracker #(
        .STAGES (STAGES),
        .DATA_W (ENTRY_W)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .hold      (stall),
        .flush     (flush),
        .in_valid  (accept),
        .in_data   (entry_in),
        .out_valid (out_valid),
        .out_data  (entry_out),
        .any_valid (busy)
    );

    assign out_rd      = entry_out[TAG_W-1:0];
    assign out_illegal = entry_out[TAG_W];

    // Sticky flags: clear applies before OR-ing in this cycle's result flags.
    always_comb begin
        fflags_d = fflags_q;
        if (fflags_clr) begin
            fflags_d = '0;
        end
        if (out_hs && !out_illegal) begin
            fflags_d = fflags_d | mul_flags;
        end
    end

    // Flag accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags_acc = fflags_q;

endmodule

// File: tb/tb_f_mult_ctrl.sv
// Directed self-checking bench for f_mult_ctrl (STAGES=3, TAG_W=5).
module tb_f_mult_ctrl;

    localparam int STAGES = 3;
    localparam int TAG_W  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_rm;
    logic [TAG_W-1:0]  in_rd;
    logic [2:0]        frm;
    logic              flush;
    logic [STAGES-1:0] stage_en;
    logic [2:0]        mul_rm;
    logic [4:0]        mul_flags;
    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_rd;
    logic              out_illegal;
    logic              fflags_clr;
    logic [4:0]        fflags_acc;
    logic              busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    f_mult_ctrl #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rm       (in_rm),
        .in_rd       (in_rd),
        .frm         (frm),
        .flush       (flush),
        .stage_en    (stage_en),
        .mul_rm      (mul_rm),
        .mul_flags   (mul_flags),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rd      (out_rd),
        .out_illegal (out_illegal),
        .fflags_clr  (fflags_clr),
        .fflags_acc  (fflags_acc),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] rd, input logic [2:0] rm);
        in_valid = v;
        in_rd    = rd;
        in_rm    = rm;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_rm = 3'b000; in_rd = '0; frm = 3'b000;
        flush = 1'b0; mul_flags = '0; out_ready = 1'b1; fflags_clr = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fflags", 32'(fflags_acc), 0);
        chk("rst_illegal", 32'(out_illegal), 0);
        reset = 1'b0; #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // 1. Back-to-back rd=1,2,3, latency 3
        issue(1, 1, 3'b000); #1;
        chk("t1_mul_rm", 32'(mul_rm), 0);
        chk("t1_in_ready", 32'(in_ready), 1);
        cyc();
        issue(1, 2, 3'b000); #1;
        chk("t1_c1_valid", 32'(out_valid), 0);
        chk("t1_c1_busy", 32'(busy), 1);
        cyc();
        issue(1, 3, 3'b000); #1;
        chk("t1_c2_valid", 32'(out_valid), 0);
        cyc();
        issue(0, 0, 3'b000); #1;
        chk("t1_c3_valid", 32'(out_valid), 1);
        chk("t1_c3_rd", 32'(out_rd), 1);
        cyc();
        chk("t1_c4_valid", 32'(out_valid), 1);
        chk("t1_c4_rd", 32'(out_rd), 2);
        cyc();
        chk("t1_c5_valid", 32'(out_valid), 1);
        chk("t1_c5_rd", 32'(out_rd), 3);
        cyc();
        chk("t1_c6_valid", 32'(out_valid), 0);
        chk("t1_c6_busy", 32'(busy), 0);

        // 2. Backpressure on rd=7, a competing request must not be accepted
        issue(1, 7, 3'b000); cyc();
        issue(0, 0, 3'b000); cyc(); cyc();
        out_ready = 1'b0;
        issue(1, 9, 3'b000);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_stall_valid", 32'(out_valid), 1);
            chk("t2_stall_rd", 32'(out_rd), 7);
            chk("t2_stall_in_ready", 32'(in_ready), 0);
            chk("t2_stall_en", 32'(stage_en), 0);
            cyc();
        end
        issue(0, 0, 3'b000);
        out_ready = 1'b1; #1;
        chk("t2_rel_valid", 32'(out_valid), 1);
        chk("t2_rel_rd", 32'(out_rd), 7);
        chk("t2_rel_en", 32'(stage_en), 3'b111);
        chk("t2_rel_in_ready", 32'(in_ready), 1);
        cyc();
        chk("t2_once_valid", 32'(out_valid), 0);
        chk("t2_once_busy", 32'(busy), 0);

        // 3. Dynamic rounding mode
        frm = 3'b011; issue(1, 4, 3'b111); #1;
        chk("t3_dyn_rm", 32'(mul_rm), 3'b011);
        cyc();
        frm = 3'b101; issue(1, 5, 3'b111); #1;
        chk("t3_dyn_bad_rm", 32'(mul_rm), 3'b101);
        cyc();
        frm = 3'b000; issue(0, 0, 3'b000); cyc();
        chk("t3_ok_valid", 32'(out_valid), 1);
        chk("t3_ok_rd", 32'(out_rd), 4);
        chk("t3_ok_illegal", 32'(out_illegal), 0);
        cyc();
        mul_flags = 5'b00001; #1;
        chk("t3_bad_rd", 32'(out_rd), 5);
        chk("t3_bad_illegal", 32'(out_illegal), 1);
        cyc();
        mul_flags = '0; #1;
        chk("t3_fflags_unchanged", 32'(fflags_acc), 0);
        chk("t3_done_valid", 32'(out_valid), 0);

        // 4. Flag accumulation and clear-then-OR
        issue(1, 10, 3'b000); cyc();
        issue(1, 11, 3'b001); cyc();
        issue(1, 12, 3'b100); cyc();
        issue(0, 0, 3'b000);
        mul_flags = 5'b00001; #1;
        chk("t4_rd10", 32'(out_rd), 10);
        cyc();
        mul_flags = 5'b00100; #1;
        chk("t4_rd11", 32'(out_rd), 11);
        cyc();
        chk("t4_acc_or", 32'(fflags_acc), 5'b00101);
        mul_flags = 5'b10000; fflags_clr = 1'b1; #1;
        chk("t4_rd12", 32'(out_rd), 12);
        chk("t4_rd12_illegal", 32'(out_illegal), 0);
        cyc();
        chk("t4_acc_clr_or", 32'(fflags_acc), 5'b10000);
        mul_flags = 5'b11111; #1;
        cyc();
        chk("t4_acc_clr_alone", 32'(fflags_acc), 0);
        fflags_clr = 1'b0; #1;
        cyc();
        chk("t4_no_hs_no_acc", 32'(fflags_acc), 0);
        mul_flags = '0;

        // 5. Flush with three ops in flight; the presented result still counts
        issue(1, 20, 3'b000); cyc();
        issue(1, 21, 3'b000); cyc();
        issue(1, 22, 3'b000); cyc();
        issue(1, 23, 3'b000);
        flush = 1'b1; mul_flags = 5'b00010; #1;
        chk("t5_flush_in_ready", 32'(in_ready), 0);
        chk("t5_flush_rd", 32'(out_rd), 20);
        cyc();
        flush = 1'b0; mul_flags = '0;
        issue(1, 24, 3'b000); #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_out_valid", 32'(out_valid), 0);
        chk("t5_fflags_hs", 32'(fflags_acc), 5'b00010);
        chk("t5_in_ready", 32'(in_ready), 1);
        cyc();
        issue(0, 0, 3'b000); #1;
        chk("t5_c1_valid", 32'(out_valid), 0);
        cyc();
        chk("t5_c2_valid", 32'(out_valid), 0);
        cyc();
        chk("t5_new_valid", 32'(out_valid), 1);
        chk("t5_new_rd", 32'(out_rd), 24);
        cyc();
        chk("t5_end_valid", 32'(out_valid), 0);

        // 6. Reset mid-stream under backpressure
        issue(1, 30, 3'b000); cyc();
        issue(1, 31, 3'b000); cyc();
        issue(1, 32, 3'b000); cyc();
        issue(0, 0, 3'b000);
        out_ready = 1'b0; mul_flags = 5'b11111; #1;
        chk("t6_pre_valid", 32'(out_valid), 1);
        chk("t6_pre_rd", 32'(out_rd), 30);
        reset = 1'b1;
        cyc();
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_illegal", 32'(out_illegal), 0);
        chk("t6_fflags", 32'(fflags_acc), 0);
        chk("t6_out_rd", 32'(out_rd), 0);
        reset = 1'b0; mul_flags = '0; #1;
        chk("t6_in_ready", 32'(in_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
